// File: rtl/sdram_arbiter.sv
// sdram_arbiter: round-robin two-port front end for SDRAM_Controller_v; one command and at most one read in flight.
// Latency: req sampled at E0 -> cmd_enable E0..E1 -> mN_ack E1..E2 (cmd_ready high); mN_rvalid one cycle after data_out_ready.
// Backpressure: cmd_ready low holds the command in ISSUE without limit; requesters hold req until ack; reads abort after TIMEOUT cycles.
module sdram_arbiter #(
   parameter int ADDR_W  = 23,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 1024
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                m0_req,
   input  logic                m0_wr,
   input  logic [DATA_W/8-1:0] m0_be,
   input  logic [ADDR_W-1:0]   m0_addr,
   input  logic [DATA_W-1:0]   m0_wdata,
   output logic                m0_ack,
   output logic                m0_rvalid,
   output logic [DATA_W-1:0]   m0_rdata,
   output logic                m0_err,
   input  logic                m1_req,
   input  logic                m1_wr,
   input  logic [DATA_W/8-1:0] m1_be,
   input  logic [ADDR_W-1:0]   m1_addr,
   input  logic [DATA_W-1:0]   m1_wdata,
   output logic                m1_ack,
   output logic                m1_rvalid,
   output logic [DATA_W-1:0]   m1_rdata,
   output logic                m1_err,
   input  logic                cmd_ready,
   output logic                cmd_enable,
   output logic                cmd_wr,
   output logic [DATA_W/8-1:0] cmd_byte_enable,
   output logic [ADDR_W-1:0]   cmd_address,
   output logic [DATA_W-1:0]   cmd_data_in,
   input  logic [DATA_W-1:0]   data_out,
   input  logic                data_out_ready,
   output logic                busy,
   output logic                owner
);

   localparam int WD_W = $clog2(TIMEOUT);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] ISSUE   = 2'd1;
   localparam logic [1:0] WAIT_RD = 2'd2;

   logic [1:0]      state;
   logic            last;
   logic [WD_W-1:0] wd;
   logic            elig0;
   logic            elig1;
   logic            pick;

   // Eligibility masks the stale request a port still holds in its ack cycle; ties go to the port not served last.
   always_comb begin
      elig0 = m0_req & ~m0_ack;
      elig1 = m1_req & ~m1_ack;
      pick  = 1'b0;
      if (elig0 && elig1) begin
         pick = ~last;
      end else if (elig1) begin
         pick = 1'b1;
      end
   end

   assign busy = (state != IDLE);

   // Arbitration, command issue, read-data routing and read watchdog.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state           <= IDLE;
         last            <= 1'b1;
         owner           <= 1'b0;
         wd              <= '0;
         cmd_enable      <= 1'b0;
         cmd_wr          <= 1'b0;
         cmd_byte_enable <= '0;
         cmd_address     <= '0;
         cmd_data_in     <= '0;
         m0_ack          <= 1'b0;
         m0_rvalid       <= 1'b0;
         m0_err          <= 1'b0;
         m0_rdata        <= '0;
         m1_ack          <= 1'b0;
         m1_rvalid       <= 1'b0;
         m1_err          <= 1'b0;
         m1_rdata        <= '0;
      end else begin
         m0_ack    <= 1'b0;
         m0_rvalid <= 1'b0;
         m0_err    <= 1'b0;
         m1_ack    <= 1'b0;
         m1_rvalid <= 1'b0;
         m1_err    <= 1'b0;
         case (state)
            IDLE: begin
               if (elig0 || elig1) begin
                  owner           <= pick;
                  last            <= pick;
                  cmd_enable      <= 1'b1;
                  cmd_wr          <= pick ? m1_wr    : m0_wr;
                  cmd_byte_enable <= pick ? m1_be    : m0_be;
                  cmd_address     <= pick ? m1_addr  : m0_addr;
                  cmd_data_in     <= pick ? m1_wdata : m0_wdata;
                  state           <= ISSUE;
               end
            end
            ISSUE: begin
               if (cmd_enable && cmd_ready) begin
                  cmd_enable <= 1'b0;
                  if (owner) begin
                     m1_ack <= 1'b1;
                  end else begin
                     m0_ack <= 1'b1;
                  end
                  if (cmd_wr) begin
                     state <= IDLE;
                  end else begin
                     wd    <= '0;
                     state <= WAIT_RD;
                  end
               end
            end
            WAIT_RD: begin
               if (data_out_ready) begin
                  if (owner) begin
                     m1_rdata  <= data_out;
                     m1_rvalid <= 1'b1;
                  end else begin
                     m0_rdata  <= data_out;
                     m0_rvalid <= 1'b1;
                  end
                  state <= IDLE;
               end else if (wd == WD_W'(TIMEOUT - 1)) begin
                  if (owner) begin
                     m1_err <= 1'b1;
                  end else begin
                     m0_err <= 1'b1;
                  end
                  state <= IDLE;
               end else begin
                  wd <= wd + WD_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed scenarios plus randomized traffic against a transaction-level model of the arbiter.
// Latency: model predicts every registered output one edge ahead and is compared on each falling edge.
// Backpressure: a controller stub drives cmd_ready (fixed, random or stalled) and returns read data after a set latency.
module tb_sdram_arbiter;
   localparam int TIMEOUT = 16;

   logic clk = 1'b0;
   logic rst;
   logic m0_req, m0_wr, m0_ack, m0_rvalid, m0_err;
   logic [3:0] m0_be;
   logic [22:0] m0_addr;
   logic [31:0] m0_wdata, m0_rdata;
   logic m1_req, m1_wr, m1_ack, m1_rvalid, m1_err;
   logic [3:0] m1_be;
   logic [22:0] m1_addr;
   logic [31:0] m1_wdata, m1_rdata;
   logic cmd_ready, cmd_enable, cmd_wr;
   logic [3:0] cmd_byte_enable;
   logic [22:0] cmd_address;
   logic [31:0] cmd_data_in, data_out;
   logic data_out_ready, busy, owner;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   sdram_arbiter #(.ADDR_W(23), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_wr(m0_wr), .m0_be(m0_be), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_ack(m0_ack), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
      .m1_req(m1_req), .m1_wr(m1_wr), .m1_be(m1_be), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_ack(m1_ack), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
      .cmd_ready(cmd_ready), .cmd_enable(cmd_enable), .cmd_wr(cmd_wr),
      .cmd_byte_enable(cmd_byte_enable), .cmd_address(cmd_address), .cmd_data_in(cmd_data_in),
      .data_out(data_out), .data_out_ready(data_out_ready), .busy(busy), .owner(owner)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- controller stub ----------------
   int stub_lat = 5;
   int ready_mode = 0;   // 0 always ready, 1 random, 2 stalled
   bit stub_rand = 0;
   bit stub_mute = 0;
   bit inject_req = 0;
   int rd_cnt = -1;
   logic [22:0] rd_addr = '0;
   logic [31:0] mem [int];

   function automatic logic [31:0] mem_rd(input logic [22:0] a);
      if (mem.exists(int'(a))) return mem[int'(a)];
      return 32'hA5A5_0000 ^ {9'd0, a};
   endfunction

   initial begin
      logic [31:0] w;
      cmd_ready = 1'b0;
      data_out_ready = 1'b0;
      data_out = '0;
      forever begin
         @(posedge clk);
         #2;
         data_out_ready = 1'b0;
         data_out = $urandom;
         if (rd_cnt > 0) begin
            rd_cnt--;
            if (rd_cnt == 0) begin
               data_out_ready = 1'b1;
               data_out = mem_rd(rd_addr);
               rd_cnt = -1;
            end
         end
         if (inject_req) begin
            data_out_ready = 1'b1;
            data_out = 32'h0BAD_0BAD;
            inject_req = 0;
         end else if (stub_rand && rd_cnt < 0 && $urandom_range(0, 49) == 0) begin
            data_out_ready = 1'b1;
         end
         case (ready_mode)
            0: cmd_ready = 1'b1;
            1: cmd_ready = ($urandom_range(0, 3) != 0);
            default: cmd_ready = 1'b0;
         endcase
         if (rst === 1'b1 && cmd_enable === 1'b1 && cmd_ready) begin
            if (cmd_wr) begin
               w = mem_rd(cmd_address);
               for (int b = 0; b < 4; b++)
                  if (cmd_byte_enable[b]) w[8*b +: 8] = cmd_data_in[8*b +: 8];
               mem[int'(cmd_address)] = w;
            end else begin
               rd_addr = cmd_address;
               if (stub_mute) rd_cnt = -1;
               else if (stub_rand) rd_cnt = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(1, 6));
               else rd_cnt = stub_lat;
            end
         end
      end
   end

   // ---------------- transaction-level model + per-cycle compare ----------------
   logic        e_ack[2], e_rv[2], e_err[2];
   logic [31:0] e_rdata[2];
   logic        e_en, e_wr, e_owner;
   logic [3:0]  e_be;
   logic [22:0] e_addr;
   logic [31:0] e_wdat;
   int  last_port;
   bit  job_open, job_offered, model_ok = 0;
   int  cyc = 0, deadline = 0;

   always @(negedge clk) begin
      bit el0, el1;
      int g, o;
      if (model_ok) begin
         check("m0_ack", 64'(m0_ack), 64'(e_ack[0]));
         check("m1_ack", 64'(m1_ack), 64'(e_ack[1]));
         check("m0_rvalid", 64'(m0_rvalid), 64'(e_rv[0]));
         check("m1_rvalid", 64'(m1_rvalid), 64'(e_rv[1]));
         check("m0_err", 64'(m0_err), 64'(e_err[0]));
         check("m1_err", 64'(m1_err), 64'(e_err[1]));
         check("m0_rdata", 64'(m0_rdata), 64'(e_rdata[0]));
         check("m1_rdata", 64'(m1_rdata), 64'(e_rdata[1]));
         check("cmd_enable", 64'(cmd_enable), 64'(e_en));
         check("cmd_wr", 64'(cmd_wr), 64'(e_wr));
         check("cmd_byte_enable", 64'(cmd_byte_enable), 64'(e_be));
         check("cmd_address", 64'(cmd_address), 64'(e_addr));
         check("cmd_data_in", 64'(cmd_data_in), 64'(e_wdat));
         check("busy", 64'(busy), 64'(job_open));
         check("owner", 64'(owner), 64'(e_owner));
      end
      cyc++;
      if (rst === 1'b0) begin
         for (int p = 0; p < 2; p++) begin
            e_ack[p] = 0; e_rv[p] = 0; e_err[p] = 0; e_rdata[p] = '0;
         end
         e_en = 0; e_wr = 0; e_be = '0; e_addr = '0; e_wdat = '0; e_owner = 0;
         last_port = 1; job_open = 0; job_offered = 0; model_ok = 1;
      end else if (model_ok) begin
         el0 = m0_req && !e_ack[0];
         el1 = m1_req && !e_ack[1];
         for (int p = 0; p < 2; p++) begin
            e_ack[p] = 0; e_rv[p] = 0; e_err[p] = 0;
         end
         o = int'(e_owner);
         if (!job_open) begin
            if (el0 || el1) begin
               g = (el0 && el1) ? (last_port == 0 ? 1 : 0) : (el0 ? 0 : 1);
               e_wr   = g ? m1_wr : m0_wr;
               e_be   = g ? m1_be : m0_be;
               e_addr = g ? m1_addr : m0_addr;
               e_wdat = g ? m1_wdata : m0_wdata;
               e_owner = (g == 1);
               last_port = g;
               e_en = 1; job_open = 1; job_offered = 1;
            end
         end else if (job_offered) begin
            if (cmd_ready) begin
               e_en = 0; e_ack[o] = 1; job_offered = 0;
               if (e_wr) job_open = 0;
               else deadline = cyc + TIMEOUT;
            end
         end else begin
            if (data_out_ready) begin
               e_rdata[o] = data_out; e_rv[o] = 1; job_open = 0;
            end else if (cyc == deadline) begin
               e_err[o] = 1; job_open = 0;
            end
         end
      end
   end

   // Order in which ports were granted (rising cmd_enable).
   int grant_log[$];
   logic prev_en = 1'b0;
   always @(negedge clk) begin
      if (cmd_enable === 1'b1 && !prev_en) grant_log.push_back(int'(owner));
      prev_en = (cmd_enable === 1'b1);
   end

   // ---------------- requester helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_port(input int p, input logic r, input logic w, input logic [3:0] b,
                           input logic [22:0] a, input logic [31:0] d);
      if (p == 0) begin m0_req = r; m0_wr = w; m0_be = b; m0_addr = a; m0_wdata = d; end
      else        begin m1_req = r; m1_wr = w; m1_be = b; m1_addr = a; m1_wdata = d; end
   endtask

   task automatic set_req(input int p, input logic r);
      if (p == 0) m0_req = r; else m1_req = r;
   endtask

   function automatic logic ack_of(input int p);
      return (p == 0) ? m0_ack : m1_ack;
   endfunction

   function automatic logic req_of(input int p);
      return (p == 0) ? m0_req : m1_req;
   endfunction

   task automatic do_cmd(input int p, input logic w, input logic [3:0] b, input logic [22:0] a, input logic [31:0] d);
      bit got = 0;
      set_port(p, 1'b1, w, b, a, d);
      for (int i = 0; i < 200; i++) begin
         step();
         if (ack_of(p)) begin got = 1; break; end
      end
      set_req(p, 1'b0);
      if (!got) check("ack_wait_expired", 64'd0, 64'd1);
   endtask

   task automatic wait_rd(input int p, output logic [31:0] d, output bit v, output bit e);
      d = '0; v = 0; e = 0;
      for (int i = 0; i < 100; i++) begin
         step();
         if ((p == 0 ? m0_rvalid : m1_rvalid) === 1'b1) begin v = 1; d = (p == 0) ? m0_rdata : m1_rdata; break; end
         if ((p == 0 ? m0_err : m1_err) === 1'b1) begin e = 1; break; end
      end
   endtask

   task automatic port_reads(input int p, input int n, input logic [22:0] a, input logic [31:0] exp);
      logic [31:0] d;
      bit v, e;
      for (int k = 0; k < n; k++) begin
         do_cmd(p, 1'b0, 4'hF, a, 32'd0);
         wait_rd(p, d, v, e);
         check("t2_rvalid", 64'(v), 64'd1);
         check("t2_rdata", 64'(d), 64'(exp));
      end
   endtask

   task automatic rnd_port(input int p);
      if (req_of(p)) begin
         if (ack_of(p)) begin
            if ($urandom_range(0, 1) == 1)
               set_port(p, 1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)), 23'($urandom_range(0, 7)), $urandom);
            else
               set_req(p, 1'b0);
         end
      end else if ($urandom_range(0, 3) == 0) begin
         set_port(p, 1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)), 23'($urandom_range(0, 7)), $urandom);
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [31:0] d;
      bit v, e;
      int n0, acks, errs, rvs, first_k;
      rst = 1'b0;
      set_port(0, 1'b0, 1'b0, 4'h0, 23'd0, 32'd0);
      set_port(1, 1'b0, 1'b0, 4'h0, 23'd0, 32'd0);
      repeat (3) step();
      rst = 1'b1;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_owner", 64'(owner), 64'd0);
      check("rst_cmd_enable", 64'(cmd_enable), 64'd0);
      check("rst_m1_rdata", 64'(m1_rdata), 64'd0);

      // Write then read back on port 0, read latency 5.
      stub_lat = 5;
      do_cmd(0, 1'b1, 4'hF, 23'h000123, 32'hDEADBEEF);
      do_cmd(0, 1'b0, 4'hF, 23'h000123, 32'd0);
      wait_rd(0, d, v, e);
      check("t1_rvalid", 64'(v), 64'd1);
      check("t1_err", 64'(e), 64'd0);
      check("t1_rdata", 64'(d), 64'hDEADBEEF);

      // Both ports read from reset at the same edge; strict alternation.
      rst = 1'b0;
      step();
      rst = 1'b1;
      grant_log.delete();
      fork
         port_reads(0, 4, 23'h000010, 32'hA5A50010);
         port_reads(1, 4, 23'h000020, 32'hA5A50020);
      join
      check("t2_grants", 64'(grant_log.size()), 64'd8);
      for (int i = 0; i < grant_log.size() && i < 8; i++)
         check("t2_order", 64'(grant_log[i]), 64'(i % 2));

      // Controller stalls for 7 cycles while a port 1 write is offered.
      ready_mode = 2;
      set_port(1, 1'b1, 1'b1, 4'h3, 23'h0ABCDE, 32'h12345678);
      for (int i = 0; i < 10 && cmd_enable !== 1'b1; i++) step();
      acks = 0;
      for (int i = 0; i < 7; i++) begin
         step();
         check("t3_en_held", 64'(cmd_enable), 64'd1);
         check("t3_addr_held", 64'(cmd_address), 64'h0ABCDE);
         check("t3_wr_held", 64'(cmd_wr), 64'd1);
         if (m1_ack) acks++;
      end
      ready_mode = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (m1_ack) begin acks++; set_req(1, 1'b0); end
         if (m1_err) check("t3_err", 64'd1, 64'd0);
      end
      check("t3_acks", 64'(acks), 64'd1);

      // Unanswered port 1 read times out; a late strobe is dropped.
      stub_mute = 1;
      do_cmd(1, 1'b0, 4'hF, 23'h000055, 32'd0);
      errs = 0; rvs = 0; first_k = -1;
      for (int k = 1; k <= 40; k++) begin
         step();
         if (m1_err) begin errs++; if (first_k < 0) first_k = k; end
         if (m1_rvalid) rvs++;
         if (first_k > 0 && k == first_k + 3) inject_req = 1;
      end
      stub_mute = 0;
      check("t4_err_count", 64'(errs), 64'd1);
      check("t4_err_cycle", 64'(first_k), 64'(TIMEOUT));
      check("t4_no_rvalid", 64'(rvs), 64'd0);
      do_cmd(0, 1'b0, 4'hF, 23'h000010, 32'd0);
      wait_rd(0, d, v, e);
      check("t4_next_rdata", 64'(d), 64'hA5A50010);

      // Port 0 keeps req high through its ack cycles: one command per ack.
      n0 = grant_log.size();
      acks = 0;
      set_port(0, 1'b1, 1'b1, 4'hF, 23'h000100, 32'h00000001);
      for (int i = 0; i < 60 && acks < 3; i++) begin
         step();
         if (m0_ack) begin
            acks++;
            if (acks < 3) set_port(0, 1'b1, 1'b1, 4'hF, 23'(23'h000100 + acks), 32'(acks + 1));
            else set_req(0, 1'b0);
         end
      end
      repeat (5) step();
      check("t5_acks", 64'(acks), 64'd3);
      check("t5_grants", 64'(grant_log.size() - n0), 64'd3);

      // Reset while a read is pending; the late data must be ignored.
      stub_lat = 8;
      do_cmd(0, 1'b0, 4'hF, 23'h000020, 32'd0);
      step();
      step();
      rst = 1'b0;
      step();
      rst = 1'b1;
      check("t6_busy", 64'(busy), 64'd0);
      check("t6_cmd_enable", 64'(cmd_enable), 64'd0);
      check("t6_m0_rdata", 64'(m0_rdata), 64'd0);
      rvs = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (m0_rvalid) rvs++;
      end
      check("t6_no_rvalid", 64'(rvs), 64'd0);

      // Randomized traffic with random backpressure, latencies, timeouts and rare resets.
      ready_mode = 1;
      stub_rand = 1;
      for (int c = 0; c < 3000; c++) begin
         step();
         rst = ($urandom_range(0, 399) != 0);
         rnd_port(0);
         rnd_port(1);
      end
      rst = 1'b1;
      ready_mode = 0;
      stub_rand = 0;
      set_req(0, 1'b0);
      set_req(1, 1'b0);
      repeat (30) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_time_limit: got expired want finished");
      bad++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
